// File: rtl/led_mux_pkg.sv
// Shared mode encodings and counter sizing for the LED mux controller.
package led_mux_pkg;

    localparam logic [1:0] MODE_A     = 2'd0;
    localparam logic [1:0] MODE_B     = 2'd1;
    localparam logic [1:0] MODE_XOR   = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced press (active-low button).
module key_debounce
    import led_mux_pkg::*;
#(
    parameter int DEB_CNT = 1000000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_flag
);

    localparam int              CW      = cnt_width(DEB_CNT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CNT - 1);

    logic          key_m;
    logic          key_s;
    logic          key_state_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            key_m       <= 1'b1;
            key_s       <= 1'b1;
            key_state   <= 1'b1;
            key_state_d <= 1'b1;
            cnt         <= '0;
            key_flag    <= 1'b0;
        end else begin
            key_m       <= key_in;
            key_s       <= key_m;
            key_state_d <= key_state;
            // Pulse follows the registered 1->0 edge of the debounced level.
            key_flag    <= key_state_d & ~key_state;
            if (key_s == key_state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_state <= key_s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_mux_ctrl.sv
// LED bank driver: debounced key steps A / B / XOR / BLINK modes, registered output.
// Define LED_MUX_ACTIVE_LOW_EN for LEDs wired to VCC (output inverted, reset all ones).
module led_mux_ctrl
    import led_mux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEB_CNT   = 1000000,
    parameter int BLINK_CNT = 25000000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             key_in,
    output logic [WIDTH-1:0] led_out,
    output logic [1:0]       mode,
    output logic             key_flag
);

    localparam int            BW        = cnt_width(BLINK_CNT);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CNT - 1);

`ifdef LED_MUX_ACTIVE_LOW_EN
    localparam logic [WIDTH-1:0] LED_POL = {WIDTH{1'b1}};
`else
    localparam logic [WIDTH-1:0] LED_POL = '0;
`endif

    logic             key_state;
    logic             press;
    logic [BW-1:0]    blink_cnt;
    logic             blink;
    logic [WIDTH-1:0] led_nxt;

    key_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_key_debounce (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .key_in    (key_in),
        .key_state (key_state),
        .key_flag  (key_flag)
    );

    // The pulse is only honoured while the debounced level still reads pressed.
    assign press = key_flag & ~key_state;

    always_comb begin
        led_nxt = '0;
        case (mode)
            MODE_A:     led_nxt = a;
            MODE_B:     led_nxt = b;
            MODE_XOR:   led_nxt = a ^ b;
            MODE_BLINK: led_nxt = blink ? a : '0;
            default:    led_nxt = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode      <= MODE_A;
            blink_cnt <= '0;
            blink     <= 1'b1;
            led_out   <= LED_POL;
        end else begin
            // A mode change restarts the blink phase lit, for a full half-period.
            if (press) begin
                mode      <= mode + 2'd1;
                blink_cnt <= '0;
                blink     <= 1'b1;
            end else if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            led_out <= led_nxt ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_led_mux_ctrl.sv
// Directed + randomized bench for led_mux_ctrl (WIDTH=4, DEB_CNT=4, BLINK_CNT=3).
module tb_led_mux_ctrl;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
    localparam int BLINK = 3;

    logic             Clk;
    logic             Rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             key_in;
    logic [WIDTH-1:0] led_out;
    logic [1:0]       mode;
    logic             key_flag;

    int         checks;
    int         failures;
    int         cyc;
    int         t_chg;
    logic [1:0] exp_mode;

    led_mux_ctrl #(
        .WIDTH     (WIDTH),
        .DEB_CNT   (DEB),
        .BLINK_CNT (BLINK)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .a        (a),
        .b        (b),
        .key_in   (key_in),
        .led_out  (led_out),
        .mode     (mode),
        .key_flag (key_flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [WIDTH-1:0] led_pol(input logic [WIDTH-1:0] v);
`ifdef LED_MUX_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Expected LED value j edges after the most recent mode change (j >= 1).
    function automatic logic [WIDTH-1:0] model_led(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] a_v,
                                                   input logic [WIDTH-1:0] b_v,
                                                   input int j);
        logic [WIDTH-1:0] v;
        int half;
        half = (j - 1) / BLINK;
        case (m)
            2'd0:    v = a_v;
            2'd1:    v = b_v;
            2'd2:    v = a_v ^ b_v;
            default: v = (half % 2 == 0) ? a_v : '0;
        endcase
        return led_pol(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc++;
    endtask

    task automatic check_cycle(input logic exp_flag);
        chk("key_flag", 32'(key_flag), 32'(exp_flag));
        chk("mode", 32'(mode), 32'(exp_mode));
        if (cyc - t_chg >= 1)
            chk("led_out", 32'(led_out), 32'(model_led(exp_mode, a, b, cyc - t_chg)));
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            tick();
            check_cycle(1'b0);
            if (rnd) begin
                a = 4'($urandom_range(15, 0));
                b = 4'($urandom_range(15, 0));
            end
        end
    endtask

    // Hold the key low for 'hold' cycles, then release and watch for 12 cycles.
    task automatic press(input int hold);
        key_in = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == DEB + 3) begin
                exp_mode = exp_mode + 2'd1;
                t_chg    = cyc;
            end
            check_cycle(i == DEB + 2);
        end
        key_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_cycle(1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        t_chg    = 0;
        exp_mode = 2'd0;
        Rst_n    = 1'b1;
        key_in   = 1'b1;
        a        = '0;
        b        = '0;

        // Asynchronous reset asserted mid-cycle takes effect immediately.
        tick();
        tick();
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_led_out", 32'(led_out), 32'(led_pol(4'h0)));
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_key_flag", 32'(key_flag), 32'd0);
        tick();
        a     = 4'hA;
        b     = 4'h5;
        Rst_n = 1'b1;
        t_chg = cyc;
        run(1, 1'b0);

        // Bouncing key: never stable long enough.
        for (int i = 0; i < 30; i++) begin
            key_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check_cycle(1'b0);
        end
        key_in = 1'b1;
        run(10, 1'b0);

        // Mode 0 -> 1, then random sources.
        press(20);
        run(10, 1'b1);

        // Mode 1 -> 2 (XOR).
        a = 4'hA;
        b = 4'h5;
        press(20);
        run(10, 1'b1);

        // Mode 2 -> 3 (BLINK), pattern followed with a=A then random.
        a = 4'hA;
        b = 4'h5;
        press(20);
        run(10, 1'b1);

        // Wait for an off phase, then press to wrap back to mode 0.
        a = 4'hA;
        b = 4'h5;
        for (int g = 0; g < 2 * BLINK && (((cyc - t_chg - 1) / BLINK) % 2 == 0); g++)
            run(1, 1'b0);
        press(20);
        run(5, 1'b1);

        // Reset in the middle of a debounce window while the key stays held.
        a = 4'hA;
        b = 4'h5;
        press(20);
        key_in = 1'b0;
        tick();
        check_cycle(1'b0);
        tick();
        check_cycle(1'b0);
        #2 Rst_n = 1'b0;
        #1;
        chk("rst2_led_out", 32'(led_out), 32'(led_pol(4'h0)));
        chk("rst2_mode", 32'(mode), 32'd0);
        chk("rst2_key_flag", 32'(key_flag), 32'd0);
        exp_mode = 2'd0;
        tick();
        Rst_n = 1'b1;
        t_chg = cyc;
        press(20);
        run(5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
